// File: rtl/vm2002_pkg.sv
// Shared vm2002 types: coin denominations, status, change-dispenser states and coin values.
package vm2002_pkg;

  typedef enum logic [1:0] {
    NICKEL      = 2'd0,
    DIME        = 2'd1,
    QUARTER     = 2'd2,
    ILLEGALCOIN = 2'd3
  } coins_t;

  typedef enum logic {
    AVAILABE = 1'b0,
    ERROR    = 1'b1
  } status_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    PRESENT = 3'd2,
    DONE    = 3'd3,
    SHORT   = 3'd4
  } chg_state_t;

  localparam int QUARTER_UNITS = 5;
  localparam int DIME_UNITS    = 2;
  localparam int NICKEL_UNITS  = 1;

  // Value of a coin in nickel units; an illegal coin is worth nothing.
  function automatic logic [2:0] coin_units(input coins_t c);
    case (c)
      QUARTER: return 3'(QUARTER_UNITS);
      DIME:    return 3'(DIME_UNITS);
      NICKEL:  return 3'(NICKEL_UNITS);
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm2002_coin_inventory.sv
// Three saturating coin counters (nickel, dime, quarter) with refill and eject-decrement ports.
module vm2002_coin_inventory
  import vm2002_pkg::*;
#(
  parameter int INV_W    = 6,
  parameter int INV_INIT = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             refill_valid,
  input  coins_t           refill_coin,
  input  logic [INV_W-1:0] refill_qty,
  input  logic             dec_valid,
  input  coins_t           dec_coin,
  output logic [INV_W-1:0] inv_quarter,
  output logic [INV_W-1:0] inv_dime,
  output logic [INV_W-1:0] inv_nickel
);

  // Counter index equals the coin code: 0 nickel, 1 dime, 2 quarter.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    localparam logic [1:0] C_CODE = 2'(gi);

    logic [INV_W-1:0] r_cnt;
    logic             w_add_en;
    logic             w_dec_en;
    logic [INV_W:0]   w_sum;

    assign w_add_en = refill_valid && (refill_coin == coins_t'(C_CODE));
    assign w_dec_en = dec_valid && (dec_coin == coins_t'(C_CODE)) && (r_cnt != '0);
    // Refill and decrement are netted first, then saturated as one step.
    assign w_sum = {1'b0, r_cnt}
                 + (w_add_en ? {1'b0, refill_qty} : {(INV_W+1){1'b0}})
                 - {{INV_W{1'b0}}, w_dec_en};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= INV_W'(INV_INIT);
      end else begin
        r_cnt <= w_sum[INV_W] ? {INV_W{1'b1}} : w_sum[INV_W-1:0];
      end
    end
  end

  assign inv_nickel  = g_cnt[0].r_cnt;
  assign inv_dime    = g_cnt[1].r_cnt;
  assign inv_quarter = g_cnt[2].r_cnt;

endmodule

// File: rtl/vm2002_change_dispenser.sv
// Change dispenser: pays an amount greedily (quarter, dime, nickel), one coin per ack.
// Inventory limits, refills and shortfall reporting exist only with VM2002_COIN_INVENTORY_EN.
module vm2002_change_dispenser
  import vm2002_pkg::*;
#(
  parameter int AMT_W    = 8,
  parameter int INV_W    = 6,
  parameter int INV_INIT = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chg_valid,
  output logic             chg_ready,
  input  logic [AMT_W-1:0] chg_amount,
  output logic             coin_valid,
  output coins_t           coin,
  input  logic             coin_ack,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] short_amount,
  output status_t          status,
  input  logic             refill_valid,
  input  coins_t           refill_coin,
  input  logic [INV_W-1:0] refill_qty,
  output logic [INV_W-1:0] inv_quarter,
  output logic [INV_W-1:0] inv_dime,
  output logic [INV_W-1:0] inv_nickel
);

  chg_state_t       r_state;
  logic [AMT_W-1:0] r_rem;
  coins_t           r_coin;
  logic             r_coin_valid;
  logic             r_done;
  logic             r_short;
  logic [AMT_W-1:0] r_short_amount;
  status_t          r_status;

  logic w_ack_take;
  logic w_have_q;
  logic w_have_d;
  logic w_have_n;

  assign w_ack_take = (r_state == PRESENT) && coin_ack;

`ifdef VM2002_COIN_INVENTORY_EN
  logic [INV_W-1:0] w_inv_q;
  logic [INV_W-1:0] w_inv_d;
  logic [INV_W-1:0] w_inv_n;

  vm2002_coin_inventory #(
    .INV_W    (INV_W),
    .INV_INIT (INV_INIT)
  ) u_inventory (
    .clk          (clk),
    .rst_n        (rst_n),
    .refill_valid (refill_valid),
    .refill_coin  (refill_coin),
    .refill_qty   (refill_qty),
    .dec_valid    (w_ack_take),
    .dec_coin     (r_coin),
    .inv_quarter  (w_inv_q),
    .inv_dime     (w_inv_d),
    .inv_nickel   (w_inv_n)
  );

  assign w_have_q    = (w_inv_q != '0);
  assign w_have_d    = (w_inv_d != '0);
  assign w_have_n    = (w_inv_n != '0);
  assign inv_quarter = w_inv_q;
  assign inv_dime    = w_inv_d;
  assign inv_nickel  = w_inv_n;
`else
  // Unlimited stock: every denomination is always available, so SHORT is never entered.
  logic w_unused_refill;
  assign w_unused_refill = ^{refill_valid, refill_coin, refill_qty, INV_W'(INV_INIT)};
  assign w_have_q    = 1'b1;
  assign w_have_d    = 1'b1;
  assign w_have_n    = 1'b1;
  assign inv_quarter = '0;
  assign inv_dime    = '0;
  assign inv_nickel  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_rem          <= '0;
      r_coin         <= NICKEL;
      r_coin_valid   <= 1'b0;
      r_done         <= 1'b0;
      r_short        <= 1'b0;
      r_short_amount <= '0;
      r_status       <= AVAILABE;
    end else begin
      r_done  <= 1'b0;
      r_short <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (chg_valid) begin
            r_rem          <= chg_amount;
            r_status       <= AVAILABE;
            r_short_amount <= '0;
            r_state        <= SELECT;
          end
        end
        SELECT: begin
          if (r_rem == '0) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_rem >= AMT_W'(QUARTER_UNITS) && w_have_q) begin
            r_coin       <= QUARTER;
            r_coin_valid <= 1'b1;
            r_state      <= PRESENT;
          end else if (r_rem >= AMT_W'(DIME_UNITS) && w_have_d) begin
            r_coin       <= DIME;
            r_coin_valid <= 1'b1;
            r_state      <= PRESENT;
          end else if (r_rem >= AMT_W'(NICKEL_UNITS) && w_have_n) begin
            r_coin       <= NICKEL;
            r_coin_valid <= 1'b1;
            r_state      <= PRESENT;
          end else begin
            r_short        <= 1'b1;
            r_short_amount <= r_rem;
            r_status       <= ERROR;
            r_state        <= SHORT;
          end
        end
        PRESENT: begin
          // Thresholds were checked in SELECT, so this cannot underflow.
          if (coin_ack) begin
            r_rem        <= r_rem - AMT_W'(coin_units(r_coin));
            r_coin_valid <= 1'b0;
            r_state      <= SELECT;
          end
        end
        DONE:    r_state <= IDLE;
        SHORT:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign chg_ready    = (r_state == IDLE);
  assign coin_valid   = r_coin_valid;
  assign coin         = r_coin;
  assign done         = r_done;
  assign short        = r_short;
  assign short_amount = r_short_amount;
  assign status       = r_status;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Scoreboard bench for vm2002_change_dispenser; adapts expectations to VM2002_COIN_INVENTORY_EN.
module tb_vm2002_change_dispenser;
  import vm2002_pkg::*;

`ifdef VM2002_COIN_INVENTORY_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif
  localparam int INV_MAX  = 63;
  localparam int INV_INIT = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       chg_valid = 1'b0;
  logic       chg_ready;
  logic [7:0] chg_amount = 8'd0;
  logic       coin_valid;
  coins_t     coin;
  logic       coin_ack = 1'b0;
  logic       done;
  logic       short;
  logic [7:0] short_amount;
  status_t    status;
  logic       refill_valid = 1'b0;
  coins_t     refill_coin = NICKEL;
  logic [5:0] refill_qty = 6'd0;
  logic [5:0] inv_quarter;
  logic [5:0] inv_dime;
  logic [5:0] inv_nickel;

  vm2002_change_dispenser dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .chg_valid    (chg_valid),
    .chg_ready    (chg_ready),
    .chg_amount   (chg_amount),
    .coin_valid   (coin_valid),
    .coin         (coin),
    .coin_ack     (coin_ack),
    .done         (done),
    .short        (short),
    .short_amount (short_amount),
    .status       (status),
    .refill_valid (refill_valid),
    .refill_coin  (refill_coin),
    .refill_qty   (refill_qty),
    .inv_quarter  (inv_quarter),
    .inv_dime     (inv_dime),
    .inv_nickel   (inv_nickel)
  );

  always #5 clk = ~clk;

  // Expected event: kind 0 = coin, 1 = done, 2 = short.
  typedef struct {
    int kind;
    int coin;
    int amt;
  } exp_t;

  exp_t exp_q[$];
  int   m_inv[3];   // reference stock indexed by coin code: 0 N, 1 D, 2 Q
  int   n_checks = 0;
  int   n_fail = 0;
  int   txn = 0;

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Greedy payout from the rules: biggest coin that fits the remainder and is in stock.
  task automatic push_expected(input int amt);
    int   rem;
    exp_t e;
    bit   fin;
    rem = amt;
    fin = 1'b0;
    while (!fin) begin
      e.kind = 0; e.coin = 0; e.amt = 0;
      if (rem == 0) begin
        e.kind = 1; fin = 1'b1;
      end else if (rem >= 5 && (!INV_EN || m_inv[2] > 0)) begin
        e.coin = 2; rem -= 5; m_inv[2] -= INV_EN ? 1 : 0;
      end else if (rem >= 2 && (!INV_EN || m_inv[1] > 0)) begin
        e.coin = 1; rem -= 2; m_inv[1] -= INV_EN ? 1 : 0;
      end else if (rem >= 1 && (!INV_EN || m_inv[0] > 0)) begin
        e.coin = 0; rem -= 1; m_inv[0] -= INV_EN ? 1 : 0;
      end else begin
        e.kind = 2; e.amt = rem; fin = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic model_refill(input int c, input int q);
    if (c < 3) m_inv[c] = min_int(m_inv[c] + q, INV_MAX);
  endtask

  task automatic check_inv();
    chk("inv_quarter", int'(inv_quarter), INV_EN ? m_inv[2] : 0);
    chk("inv_dime",    int'(inv_dime),    INV_EN ? m_inv[1] : 0);
    chk("inv_nickel",  int'(inv_nickel),  INV_EN ? m_inv[0] : 0);
  endtask

  task automatic sb_pop(input int kind, input int c, input int a);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_event_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", kind, e.kind);
      if (kind == 0 && e.kind == 0) chk("sb_coin", c, e.coin);
      if (kind == 2 && e.kind == 2) chk("sb_short_amount", a, e.amt);
    end
  endtask

  // Monitor: compares every coin handshake and terminal pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (coin_valid && coin_ack) sb_pop(0, int'(coin), 0);
      if (done) begin
        sb_pop(1, 0, 0);
        chk("done_status", int'(status), int'(AVAILABE));
        chk("done_short_amount", int'(short_amount), 0);
      end
      if (short) begin
        sb_pop(2, 0, int'(short_amount));
        chk("short_status", int'(status), int'(ERROR));
      end
    end
  end

  task automatic refill_idle(input coins_t c, input int q);
    refill_valid = 1'b1;
    refill_coin  = c;
    refill_qty   = 6'(q);
    @(posedge clk); #1;
    refill_valid = 1'b0;
    model_refill(int'(c), q);
    check_inv();
  endtask

  // Drives one request and its acks; fixed_delay >= 0 overrides the random ack delay.
  task automatic run_request(input int amt, input int fixed_delay, input int max_delay,
                             input bit sat_refill);
    int     cycles, last_ack, delay, n_coins;
    bit     finished, presenting, was_short;
    coins_t held;
    push_expected(amt);
    cycles = 0;
    while (!chg_ready && cycles < 20) begin
      @(posedge clk); #1; cycles++;
    end
    chk("ready_before_req", int'(chg_ready), 1);
    chg_valid  = 1'b1;
    chg_amount = 8'(amt);
    @(posedge clk); #1;
    chg_valid = 1'b0;
    cycles = 0; last_ack = -1; n_coins = 0;
    finished = 1'b0; presenting = 1'b0; was_short = 1'b0;
    held = NICKEL;
    delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, max_delay));
    while (!finished && cycles < 2000) begin
      if (coin_valid) begin
        if (!presenting) begin
          presenting = 1'b1;
          held = coin;
          chk("coin_latency", cycles, last_ack + 2);
        end else begin
          chk("coin_stable", int'(coin), int'(held));
        end
        if (delay == 0) begin
          coin_ack = 1'b1;
          last_ack = cycles;
          n_coins++;
          if (sat_refill) begin
            refill_valid = 1'b1;
            refill_coin  = QUARTER;
            refill_qty   = 6'd63;
            model_refill(2, 63);
          end
        end else begin
          delay--;
        end
      end else if (presenting) begin
        chk("coin_valid_held", 0, 1);
        presenting = 1'b0;
      end
      if (done || short) begin
        chk("end_latency", cycles, last_ack + 2);
        was_short = short;
        finished = 1'b1;
      end else begin
        @(posedge clk); #1;
        cycles++;
        if (coin_ack) begin
          coin_ack     = 1'b0;
          refill_valid = 1'b0;
          presenting   = 1'b0;
          delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, max_delay));
        end
      end
    end
    if (!finished) chk("request_timeout", 0, 1);
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    check_inv();
    txn++;
    $display("txn %0d: amount=%0d coins=%0d result=%s short_amount=%0d inv(Q,D,N)=%0d,%0d,%0d",
             txn, amt, n_coins, was_short ? "short" : "done", short_amount,
             inv_quarter, inv_dime, inv_nickel);
  endtask

  task automatic reset_mid_payout();
    int cyc, ncv;
    bit saw_done;
    push_expected(13);
    chg_valid  = 1'b1;
    chg_amount = 8'd13;
    @(posedge clk); #1;
    chg_valid = 1'b0;
    cyc = 0; ncv = 0;
    while (ncv < 2 && cyc < 50) begin
      if (coin_valid && !coin_ack) begin
        ncv++;
        if (ncv == 1) coin_ack = 1'b1;
      end
      if (ncv < 2) begin
        @(posedge clk); #1; cyc++;
        if (coin_ack) coin_ack = 1'b0;
      end
    end
    chk("rst_test_second_coin_seen", ncv, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_coin_valid_drop", int'(coin_valid), 0);
    chk("rst_done_low", int'(done), 0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) m_inv[i] = INV_INIT;
    check_inv();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    chk("rst_chg_ready_after_release", int'(chg_ready), 1);
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("rst_no_done", int'(saw_done), 0);
    check_inv();
    txn++;
    $display("txn %0d: amount=13 interrupted by reset after %0d coin(s)", txn, ncv);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m_inv[i] = INV_INIT;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_coin_valid", int'(coin_valid), 0);
    chk("reset_coin", int'(coin), int'(NICKEL));
    chk("reset_done", int'(done), 0);
    chk("reset_short", int'(short), 0);
    chk("reset_short_amount", int'(short_amount), 0);
    chk("reset_status", int'(status), int'(AVAILABE));
    check_inv();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_chg_ready", int'(chg_ready), 1);

    run_request(13, 0, 0, 1'b0);          // Q,Q,D,N
    run_request(100, -1, 2, 1'b0);        // drains quarters
    run_request(28, -1, 2, 1'b0);         // drains dimes
    run_request(17, -1, 2, 1'b0);         // leaves two nickels
    run_request(7, 0, 0, 1'b0);           // N,N then short 5
    refill_idle(DIME, 20);
    run_request(3, 0, 0, 1'b0);           // D then short 1
    run_request(0, 0, 0, 1'b0);           // done, status cleared
    refill_idle(QUARTER, 1);
    run_request(5, 0, 0, 1'b1);           // ack with same-cycle refill of 63 quarters
    refill_idle(NICKEL, 40);
    refill_idle(DIME, 44);
    refill_idle(ILLEGALCOIN, 9);
    run_request(5, 5, 0, 1'b0);           // ack held off for 5 cycles
    reset_mid_payout();

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1)
        refill_idle(coins_t'(2'($urandom_range(0, 3))), int'($urandom_range(0, 63)));
      run_request(int'($urandom_range(0, 40)), -1, 3, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vm2002_change_dispenser.md
# vm2002_change_dispenser

Change-return unit of the vm2002 vending machine, the outbound counterpart of the coin-acceptance path. It accepts a change amount from the vend controller and pays it out as a sequence of physical coins (`coins_t`) to the coin-ejector mechanism, one coin per handshake. Selection is greedy, largest coin first, and is bounded by per-denomination coin inventories. If the inventory cannot cover the amount, the block reports a shortfall.

## Interface
- `AMT_W`, default 8: width of change amount, in nickel units (1 unit = $0.05).
- `INV_W`, default 6: width of each coin inventory counter.
- `INV_INIT`, default 20: per-denomination inventory loaded at reset.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `chg_valid` in 1: change request valid.
- `chg_ready` out 1: block can accept a request; high only in IDLE.
- `chg_amount` in `AMT_W`: change to pay, in nickel units.
- `coin_valid` out 1: `coin` is presented to the ejector.
- `coin` out `coins_t`: denomination to eject.
- `coin_ack` in 1: ejector consumed the coin.
- `done` out 1: one-cycle pulse; the full amount has been paid.
- `short` out 1: one-cycle pulse; the amount cannot be completed.
- `short_amount` out `AMT_W`: unpaid remainder; valid with `short`, held until the next accepted request.
- `status` out `status_t`: `AVAILABE` when no shortfall is latched, `ERROR` after `short`, cleared on the next accept.
- `refill_valid` in 1: add coins to inventory.
- `refill_coin` in `coins_t`: denomination to refill.
- `refill_qty` in `INV_W`: number of coins to add.
- `inv_quarter`, `inv_dime`, `inv_nickel` out `INV_W` each: current inventory.

## Operation
- States: IDLE, SELECT, PRESENT, DONE, SHORT.
- IDLE: when `chg_valid`&`chg_ready`, latch `chg_amount` into `rem`, clear `status`/`short_amount`, and go to SELECT.
- SELECT: evaluate in priority order and take the first that applies.
  - `rem`==0: go to DONE.
  - `rem`>=5 and `inv_quarter`>0: QUARTER.
  - `rem`>=2 and `inv_dime`>0: DIME.
  - `rem`>=1 and `inv_nickel`>0: NICKEL.
  - Otherwise: go to SHORT.
  - When a coin is chosen, register it into `coin` and go to PRESENT.
- PRESENT: `coin_valid`=1, and `coin` is held stable until `coin_ack`. On ack:
  - `rem` -= value (Q=5, D=2, N=1).
  - That inventory decrements by 1.
  - Go to SELECT.
- DONE: `done`=1 for one cycle, then go to IDLE.
- SHORT: `short`=1 for one cycle, `short_amount`=`rem`, `status`=`ERROR`, then go to IDLE. Coins already ejected are not recalled.
- Refill, accepted in any state:
  - The addition saturates at 2^`INV_W`-1.
  - `ILLEGALCOIN` refills are ignored.
  - A refill and an ack-decrement of the same coin in the same cycle apply net: +qty-1, saturating.
  - A refill landing in the same cycle as a SELECT decision is not visible to that decision.
- `coin_ack` outside PRESENT is ignored.
- `chg_amount`=0: the request yields `done` with no coins.

## Timing
- Reset values:
  - State IDLE, so `chg_ready`=1 once `rst_n` is high.
  - `coin_valid`=0, `coin`=`NICKEL`.
  - `done`=0, `short`=0, `short_amount`=0, `status`=`AVAILABE`.
  - Inventories=`INV_INIT`.
- Request accept to first `coin_valid`: 2 cycles (IDLE→SELECT→PRESENT).
- Per coin, with ack in the first PRESENT cycle: 2 cycles (PRESENT→SELECT→PRESENT).
- After the last ack, `done` asserts 2 cycles later (SELECT, then DONE).
- Reset asserted mid-operation:
  - All outputs go to their reset values asynchronously.
  - `coin_valid` drops immediately.
  - The pending remainder is discarded and inventories reload `INV_INIT`.
- `rem` is `AMT_W` wide. Subtraction never underflows because the thresholds are checked first.

## Configuration
- `VM2002_COIN_INVENTORY_EN` defined:
  - Inventory counters, refill ports and the shortfall path are present as described above.
- `VM2002_COIN_INVENTORY_EN` undefined:
  - Inventory is treated as unlimited, so selection ignores counts.
  - SHORT is unreachable: `short`=0, `short_amount`=0, `status`=`AVAILABE`.
  - `inv_*` outputs are tied to 0 and refill inputs are ignored.

## Structure
- Add to `vm2002_pkg`:
  - `chg_state_t` enum (IDLE, SELECT, PRESENT, DONE, SHORT).
  - Constants `QUARTER_UNITS`=5, `DIME_UNITS`=2, `NICKEL_UNITS`=1.
- Sub-module `vm2002_coin_inventory`: three saturating counters with refill and decrement ports, `INV_INIT` reset. It is instantiated only under `VM2002_COIN_INVENTORY_EN`.

## Test plan
- Full inventory, `chg_amount`=13, immediate acks → coins Q,Q,D,N, then `done`; inventories end Q=18, D=19, N=19.
- Q=0, D=0, N=2, `chg_amount`=7 → coins N,N, then `short` with `short_amount`=5 and `status`=`ERROR`.
- N=0, D=20, `chg_amount`=3 → one D, then `short` with `short_amount`=1; `status` returns to `AVAILABE` on the next accepted request.
- `chg_amount`=5 with `coin_ack` held low for 5 cycles → `coin_valid`=1 and `coin`=`QUARTER` stable throughout; ack → `done` 2 cycles later.
- Inventory Q=1 while presenting a QUARTER: `refill_valid`(QUARTER, qty 63) in the same cycle as `coin_ack` → `inv_quarter`=63 (saturated).
- `rst_n` pulsed low during the second coin of a 13-unit payout → `coin_valid`=0 immediately, `chg_ready`=1 after release, inventories=20, and no `done`.
